// File: rtl/pc_gen.sv
// Program counter generator: boot delay, fetch handshake, redirect/trap steering, misalign halt.
// Optional macro PC_COMPRESSED_EN enables 16-bit instructions (2-byte increment and alignment).
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              BOOT_DELAY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            is_compressed,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] pc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic [31:0]     fetch_cnt,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;
  logic            mis_q, mis_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  logic            fire;
  logic            bad_target;
  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] trap_target;

  // Handshake: a fetch is accepted in any cycle where req_valid and req_ready are both high;
  // req_valid is a pure function of state (and forced low while rst_n is low), never of req_ready.
  assign req_valid = rst_n && (state_q == RUN);
  assign fire      = req_valid && req_ready;
  assign trap_target = {trap_vec[XLEN-1:2], 2'b00};

`ifdef PC_COMPRESSED_EN
  assign bad_target = redirect_pc[0];
  assign inc        = is_compressed ? XLEN'(2) : XLEN'(4);
`else
  logic unused_is_compressed;
  assign unused_is_compressed = is_compressed;
  assign bad_target = |redirect_pc[1:0];
  assign inc        = XLEN'(4);
`endif

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    mis_d       = 1'b0;
    mis_addr_d  = mis_addr_q;
    fetch_cnt_d = fire ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == 4'd0) state_d = RUN;
        else                    boot_cnt_d = boot_cnt_q - 4'd1;
      end
      RUN: begin
        if (trap_valid) begin
          pc_d = trap_target;
        end else if (redirect_valid) begin
          if (bad_target) begin
            mis_d      = 1'b1;
            mis_addr_d = redirect_pc;
            state_d    = HALT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!stall && fire) begin
          pc_d = pc_q + inc;
        end
      end
      HALT: begin
        // Only a trap can restart fetching after a rejected redirect.
        if (trap_valid) begin
          pc_d    = trap_target;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      boot_cnt_q  <= 4'(BOOT_DELAY);
      pc_q        <= RESET_ADDR;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc            = pc_q;
  assign req_addr      = pc_q;
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;
  assign fetch_cnt     = fetch_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with default boot delay, one with BOOT_DELAY=3.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, trap_valid, is_compressed, req_ready;
  logic [31:0] redirect_pc, trap_vec;

  logic        req_valid, misalign;
  logic [31:0] req_addr, pc, misalign_addr, fetch_cnt;
  logic [1:0]  state;

  logic        b_req_valid, b_misalign;
  logic [31:0] b_req_addr, b_pc, b_misalign_addr, b_fetch_cnt;
  logic [1:0]  b_state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

`ifdef PC_COMPRESSED_EN
  localparam logic [31:0] BAD_TGT = 32'h0000_0203;
`else
  localparam logic [31:0] BAD_TGT = 32'h0000_0202;
`endif

  pc_gen u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .is_compressed(is_compressed),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .pc(pc),
    .misalign(misalign), .misalign_addr(misalign_addr), .fetch_cnt(fetch_cnt),
    .state(state)
  );

  pc_gen #(.BOOT_DELAY(3)) u_boot (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .is_compressed(is_compressed),
    .req_valid(b_req_valid), .req_ready(req_ready), .req_addr(b_req_addr), .pc(b_pc),
    .misalign(b_misalign), .misalign_addr(b_misalign_addr), .fetch_cnt(b_fetch_cnt),
    .state(b_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic stl, input logic rv, input logic [31:0] rpc,
                       input logic tv, input logic [31:0] tvec, input logic rdy);
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    trap_valid     = tv;
    trap_vec       = tvec;
    req_ready      = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    is_compressed = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'h0);
    check("rst_state", {30'd0, state}, 32'd0);

    // Release reset; cycle k is the period after the k-th edge with rst_n high.
    rst_n = 1'b1;
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("boot3_valid_c%0d", k), {31'd0, b_req_valid}, (k >= 3) ? 32'd1 : 32'd0);
    end
    check("run_valid", {31'd0, req_valid}, 32'd1);
    check("hold_no_ready_addr", req_addr, 32'h0);
    check("hold_no_ready_cnt", fetch_cnt, 32'd0);

    // Sequential fetch 0, 4, 8, 12
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    req_ready = 1'b1;
    check("seq_pc0", pc, exp_q.pop_front());
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("seq_pc%0d", k), pc, exp_q.pop_front());
    end
    check("seq_req_addr", req_addr, 32'd12);
    check("seq_fetch_cnt", fetch_cnt, 32'd3);

    // Redirect beats stall
    drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    step();
    check("redir_pc_100", pc, 32'h100);
    drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    step();
    check("stall_redir_pc", pc, 32'h200);
    check("stall_redir_cnt", fetch_cnt, 32'd3);

    // Stall holds pc yet the accepted fetch still counts
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    check("stall_pc", pc, 32'h200);
    check("stall_cnt", fetch_cnt, 32'd4);

    // Trap with a simultaneous misaligned redirect: trap wins, no pulse
    drive(1'b0, 1'b1, 32'h201, 1'b1, 32'h307, 1'b0);
    step();
    check("trap_win_pc", pc, 32'h304);
    check("trap_win_mis", {31'd0, misalign}, 32'd0);
    check("trap_win_state", {30'd0, state}, 32'd1);

    // Misaligned redirect: pulse, capture, hold pc, halt
    drive(1'b0, 1'b1, BAD_TGT, 1'b0, 32'h0, 1'b1);
    step();
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_addr", misalign_addr, BAD_TGT);
    check("mis_pc_held", pc, 32'h304);
    check("mis_state_halt", {30'd0, state}, 32'd2);
    check("mis_cnt", fetch_cnt, 32'd5);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);
    check("mis_addr_held", misalign_addr, BAD_TGT);
    check("halt_valid", {31'd0, req_valid}, 32'd0);
    check("halt_cnt", fetch_cnt, 32'd5);

    // HALT ignores redirect and stall; trap restarts
    drive(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    step();
    check("halt_ign_pc", pc, 32'h304);
    check("halt_ign_state", {30'd0, state}, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h83, 1'b0);
    step();
    check("halt_trap_pc", pc, 32'h80);
    check("halt_trap_state", {30'd0, state}, 32'd1);
    check("halt_trap_valid", {31'd0, req_valid}, 32'd1);

    // Wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    step();
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_cnt", fetch_cnt, 32'd6);

    // is_compressed: honoured only in the compressed build
    is_compressed = 1'b1;
    step();
`ifdef PC_COMPRESSED_EN
    check("cmp_inc", pc, 32'h2);
    drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    check("cmp_pc_12", pc, 32'h12);
    drive(1'b0, 1'b1, 32'h21, 1'b0, 32'h0, 1'b0);
    step();
    check("cmp_mis_pulse", {31'd0, misalign}, 32'd1);
    check("cmp_mis_addr", misalign_addr, 32'h21);
`else
    check("nocmp_inc", pc, 32'h4);
`endif
    is_compressed = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset mid-run restores everything
    rst_n = 1'b0;
    step();
    check("rerst_pc", pc, 32'h0);
    check("rerst_cnt", fetch_cnt, 32'd0);
    check("rerst_valid", {31'd0, req_valid}, 32'd0);
    check("rerst_mis_addr", misalign_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
